// File: rtl/ins_mem_loader.sv
// ins_mem_loader: byte-stream to instruction-memory loader with CPU hold (rev 1.0).
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
`default_nettype none

module ins_mem_loader #(
   parameter int          MEM_DEPTH = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        err_overflow,
`ifdef LOADER_CHECKSUM_EN
   output logic        err_checksum,
`endif
   output logic [15:0] word_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_LO = 3'd1,
      S_LEN_HI = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_DONE   = 3'd5,
      S_ERROR  = 3'd6,
      S_CSUM   = 3'd7
   } state_t;

   localparam logic [16:0] c_depth = 17'(MEM_DEPTH);

   state_t      r_state;
   logic [15:0] r_length;
   logic [15:0] r_word_idx;
   logic [1:0]  r_byte_idx;
   logic [31:0] r_asm;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  r_csum;
`endif

   logic        w_take;
   logic        w_restart;
   logic [15:0] w_len;
   logic [31:0] w_word;
   logic [31:0] w_addr;

   assign w_take    = byte_valid & byte_ready;
   assign w_restart = start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERROR));
   assign w_len     = {byte_data, r_length[7:0]};
   // Bytes shift in from the top so byte 0 ends up in [7:0] after four transfers.
   assign w_word    = {byte_data, r_asm[31:8]};
   assign w_addr    = BASE_ADDR + {14'd0, r_word_idx, 2'b00};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_length     <= 16'd0;
         r_word_idx   <= 16'd0;
         r_byte_idx   <= 2'd0;
         r_asm        <= 32'd0;
         byte_ready   <= 1'b0;
         wr_en        <= 1'b0;
         wr_addr      <= 32'd0;
         wr_data      <= 32'd0;
         cpu_hold     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err_overflow <= 1'b0;
         word_count   <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
         r_csum       <= 8'd0;
         err_checksum <= 1'b0;
`endif
      end else begin
         wr_en <= 1'b0;
         if (w_restart) begin
            r_state      <= S_LEN_LO;
            r_length     <= 16'd0;
            r_word_idx   <= 16'd0;
            r_byte_idx   <= 2'd0;
            byte_ready   <= 1'b1;
            busy         <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err_overflow <= 1'b0;
            word_count   <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
            r_csum       <= 8'd0;
            err_checksum <= 1'b0;
`endif
         end else begin
            case (r_state)
               S_LEN_LO: begin
                  if (w_take) begin
                     r_length[7:0] <= byte_data;
                     r_state       <= S_LEN_HI;
                  end
               end
               S_LEN_HI: begin
                  if (w_take) begin
                     r_length[15:8] <= byte_data;
                     if (w_len == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        r_state    <= S_CSUM;
                        byte_ready <= 1'b1;
`else
                        r_state    <= S_DONE;
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        cpu_hold   <= 1'b0;
                        done       <= 1'b1;
`endif
                     end else if ({1'b0, w_len} > c_depth) begin
                        r_state      <= S_ERROR;
                        byte_ready   <= 1'b0;
                        busy         <= 1'b0;
                        err_overflow <= 1'b1;
                     end else begin
                        r_state <= S_DATA;
                     end
                  end
               end
               S_DATA: begin
                  if (w_take) begin
                     r_asm      <= w_word;
                     r_byte_idx <= r_byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                     r_csum     <= r_csum ^ byte_data;
`endif
                     if (r_byte_idx == 2'd3) begin
                        r_state    <= S_WRITE;
                        byte_ready <= 1'b0;
                        wr_en      <= 1'b1;
                        wr_addr    <= w_addr;
                        wr_data    <= w_word;
                        word_count <= word_count + 16'd1;
                     end
                  end
               end
               S_WRITE: begin
                  r_word_idx <= r_word_idx + 16'd1;
                  if (r_word_idx + 16'd1 == r_length) begin
`ifdef LOADER_CHECKSUM_EN
                     r_state    <= S_CSUM;
                     byte_ready <= 1'b1;
`else
                     r_state    <= S_DONE;
                     busy       <= 1'b0;
                     cpu_hold   <= 1'b0;
                     done       <= 1'b1;
`endif
                  end else begin
                     r_state    <= S_DATA;
                     byte_ready <= 1'b1;
                  end
               end
`ifdef LOADER_CHECKSUM_EN
               S_CSUM: begin
                  if (w_take) begin
                     byte_ready <= 1'b0;
                     busy       <= 1'b0;
                     if (byte_data == r_csum) begin
                        r_state  <= S_DONE;
                        cpu_hold <= 1'b0;
                        done     <= 1'b1;
                     end else begin
                        r_state      <= S_ERROR;
                        err_checksum <= 1'b1;
                     end
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ins_mem_loader.sv
// tb_ins_mem_loader: table-driven loads with a write scoreboard for ins_mem_loader.
`default_nettype none

module tb_ins_mem_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'd0;
   logic        byte_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        err_overflow;
   logic [15:0] word_count;
`ifdef LOADER_CHECKSUM_EN
   logic        err_checksum;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int wr_seen  = 0;
   logic [31:0] last_addr = 32'd0;
   logic [63:0] exp_q[$];

   typedef struct {
      logic [15:0]       n;
      logic [2:0][31:0]  w;
      int                gap;
      bit                poke;
      bit                csum_bad;
      bit                exp_done;
      bit                exp_ovf;
      bit                exp_cerr;
      logic [15:0]       exp_cnt;
      logic [31:0]       exp_last;
   } vec_t;

   vec_t vecs[$];

   ins_mem_loader #(.MEM_DEPTH(64), .BASE_ADDR(32'h0000_0000)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .byte_ready   (byte_ready),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .cpu_hold     (cpu_hold),
      .busy         (busy),
      .done         (done),
      .err_overflow (err_overflow),
`ifdef LOADER_CHECKSUM_EN
      .err_checksum (err_checksum),
`endif
      .word_count   (word_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Write monitor: every wr_en pulse must match the oldest expected word.
   initial begin
      logic [63:0] e;
      forever begin
         @(posedge clk); #1;
         if (wr_en === 1'b1) begin
            wr_seen++;
            last_addr = wr_addr;
            check("ready_low_in_write", {31'd0, byte_ready}, 32'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_write_addr", wr_addr, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", wr_addr, e[63:32]);
               check("wr_data", wr_data, e[31:0]);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want test end");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      for (int g = 0; g < gap; g++) begin
         byte_valid = 1'b0;
         @(posedge clk); #1;
      end
      byte_valid = 1'b1;
      byte_data  = b;
      t = 0;
      while (byte_ready !== 1'b1 && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 50) begin
         n_checks++;
         n_fail++;
         $display("FAIL byte_accept: got ready=0 for 50 cycles, want ready=1");
      end
      @(posedge clk); #1;
      byte_valid = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
      check({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
      check({tag, "_wr_addr"}, wr_addr, 32'd0);
      check({tag, "_wr_data"}, wr_data, 32'd0);
      check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
      check({tag, "_err_overflow"}, {31'd0, err_overflow}, 32'd0);
      check({tag, "_word_count"}, {16'd0, word_count}, 32'd0);
`ifdef LOADER_CHECKSUM_EN
      check({tag, "_err_checksum"}, {31'd0, err_checksum}, 32'd0);
`endif
   endtask

   function automatic logic [31:0] word_of(input vec_t v, input int i);
      if (i < 3) return v.w[i];
      return 32'h1000_0000 + 32'(i);
   endfunction

   function automatic int pick_gap(input int mx);
      if (mx == 0) return 0;
      return int'($urandom_range(mx, 0));
   endfunction

   task automatic run_vec(input vec_t v);
      logic [31:0] w;
      logic [7:0]  x;
      int          base;
      bit          ok_len;
      x    = 8'd0;
      base = wr_seen;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_busy", {31'd0, busy}, 32'd1);
      check("start_done_clear", {31'd0, done}, 32'd0);
      send_byte(v.n[7:0], pick_gap(v.gap));
      send_byte(v.n[15:8], pick_gap(v.gap));
      ok_len = (v.n <= 16'd64);
      if (ok_len) begin
         for (int i = 0; i < int'(v.n); i++) begin
            w = word_of(v, i);
            exp_q.push_back({32'(i) << 2, w});
            for (int b = 0; b < 4; b++) begin
               send_byte(w[8*b +: 8], pick_gap(v.gap));
               x = x ^ w[8*b +: 8];
               if (v.poke && i == 0 && b == 1) begin
                  start = 1'b1;
                  @(posedge clk); #1;
                  start = 1'b0;
               end
            end
         end
      end
`ifdef LOADER_CHECKSUM_EN
      if (ok_len) send_byte(v.csum_bad ? (x ^ 8'h01) : x, 0);
`endif
      repeat (3) @(posedge clk);
      #1;
      check("done", {31'd0, done}, {31'd0, v.exp_done});
      check("err_overflow", {31'd0, err_overflow}, {31'd0, v.exp_ovf});
      check("cpu_hold", {31'd0, cpu_hold}, {31'd0, v.exp_ovf | v.exp_cerr});
      check("busy_end", {31'd0, busy}, 32'd0);
      check("byte_ready_end", {31'd0, byte_ready}, 32'd0);
      check("word_count", {16'd0, word_count}, {16'd0, v.exp_cnt});
      check("write_pulses", 32'(wr_seen - base), {16'd0, v.exp_cnt});
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      if (v.exp_cnt != 16'd0) check("last_wr_addr", last_addr, v.exp_last);
`ifdef LOADER_CHECKSUM_EN
      check("err_checksum", {31'd0, err_checksum}, {31'd0, v.exp_cerr});
`endif
      exp_q.delete();
   endtask

   initial begin
      logic [2:0][31:0] prog;
      int seen_before;
      prog = {32'h002081B3, 32'h00A00113, 32'h00500093};

      //                  n       w                                      gap poke bad  done ovf cerr cnt     last
      vecs.push_back(vec_t'{16'd1,  {64'd0, 32'h0000_0013},               0,  0,   0,   1,   0,  0,  16'd1,  32'h0});
      vecs.push_back(vec_t'{16'd3,  prog,                                 0,  0,   0,   1,   0,  0,  16'd3,  32'h8});
      vecs.push_back(vec_t'{16'd3,  prog,                                 3,  0,   0,   1,   0,  0,  16'd3,  32'h8});
      vecs.push_back(vec_t'{16'd2,  prog,                                 1,  1,   0,   1,   0,  0,  16'd2,  32'h4});
      vecs.push_back(vec_t'{16'd0,  prog,                                 0,  0,   0,   1,   0,  0,  16'd0,  32'h0});
      vecs.push_back(vec_t'{16'd64, prog,                                 0,  0,   0,   1,   0,  0,  16'd64, 32'hFC});
      vecs.push_back(vec_t'{16'd1,  {64'd0, 32'hDEAD_BEEF},               0,  0,   0,   1,   0,  0,  16'd1,  32'h0});
      vecs.push_back(vec_t'{16'd65, prog,                                 0,  0,   0,   0,   1,  0,  16'd0,  32'h0});
      vecs.push_back(vec_t'{16'd1,  {64'd0, 32'h0000_0013},               2,  0,   0,   1,   0,  0,  16'd1,  32'h0});
`ifdef LOADER_CHECKSUM_EN
      vecs.push_back(vec_t'{16'd1,  {64'd0, 32'h0804_0201},               0,  0,   0,   1,   0,  0,  16'd1,  32'h0});
      vecs.push_back(vec_t'{16'd1,  {64'd0, 32'h0804_0201},               0,  0,   1,   0,   0,  1,  16'd1,  32'h0});
`endif

      #3 reset = 1'b0;
      #1 check_zero("reset");
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Reset asserted after two data bytes of the first word: load abandoned.
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      check("mid_load_busy", {31'd0, busy}, 32'd1);
      seen_before = wr_seen;
      reset = 1'b0;
      #1 check_zero("mid_reset");
      byte_valid = 1'b1;
      byte_data  = 8'hCC;
      repeat (6) @(posedge clk);
      #1;
      byte_valid = 1'b0;
      check("no_write_after_reset", 32'(wr_seen - seen_before), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      for (int k = 0; k < vecs.size(); k++) run_vec(vecs[k]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ins_mem_loader.md
Name: ins_mem_loader

Overview:
- Write-side counterpart to the instruction fetch path.
- Accepts a byte stream over a valid/ready handshake from a host-link or boot ROM, assembles little-endian 32-bit words, and issues single-cycle writes into instruction memory.
- Holds the CPU (PC/fetch) idle while a program image is loaded, then releases it so fetch starts from BASE_ADDR.

Parameters:
- MEM_DEPTH, 64, instruction memory capacity in 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-byte aligned.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts byte_data this cycle.
- wr_en  out  1  instruction memory write strobe, one cycle per word.
- wr_addr  out  32  byte address of the write.
- wr_data  out  32  assembled instruction word.
- cpu_hold  out  1  keeps PC/fetch stalled and in reset while high.
- busy  out  1  load in progress.
- done  out  1  last load completed without error; level signal.
- err_overflow  out  1  requested length exceeded MEM_DEPTH; level signal.
- word_count  out  16  words written in the current or last load.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; all outputs 0; internal length, byte index and word index cleared. Reset mid-load abandons the load with no further wr_en; words already written stay in memory.
- Transfer: a byte is taken only on a cycle where byte_valid and byte_ready are both high. byte_data is ignored otherwise.
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N×4 data bytes. Within each word, byte 0 goes to bits [7:0] and byte 3 to bits [31:24].
- States:
  - IDLE: byte_ready=0. On start → LEN_LO; busy=1, cpu_hold=1; done, err_overflow and word_count cleared.
  - LEN_LO: byte_ready=1. Accepted byte → length[7:0] → LEN_HI.
  - LEN_HI: byte_ready=1. Accepted byte → length[15:8]. Then:
    - if N==0 → DONE;
    - if N>MEM_DEPTH → ERROR;
    - else → DATA.
  - DATA: byte_ready=1. Accepts 4 bytes into the shift/assembly register; on the 4th → WRITE.
  - WRITE: byte_ready=0 for exactly one cycle; wr_en=1, wr_addr=BASE_ADDR+4×word_index, wr_data=assembled word. word_count increments in the same cycle.
    - if word_index+1==N → DONE;
    - else → DATA.
  - DONE: busy=0, cpu_hold=0, done=1; holds until start.
  - ERROR: busy=0, err_overflow=1, cpu_hold=1 (CPU stays stalled on a bad image); holds until start.
- wr_en, wr_addr and wr_data are registered. wr_addr and wr_data hold their last values when wr_en=0.
- Latency: wr_en asserts on the cycle after the 4th byte of a word is accepted. Minimum 5 cycles per word.
- start in LEN_LO, LEN_HI, DATA or WRITE is ignored. start in DONE or ERROR restarts the load.
- Arithmetic:
  - word_index and word_count saturate naturally, since N ≤ MEM_DEPTH < 2^16.
  - wr_addr is computed modulo 2^32.
- byte_valid low for any number of cycles mid-word stalls the load with no state change.

Optional Feature:
- LOADER_CHECKSUM_EN
- Defined:
  - Adds state CSUM after the last WRITE. It accepts one trailing byte, which must equal the XOR of all data bytes (length bytes excluded).
  - Match → DONE. Mismatch → ERROR with extra output err_checksum=1, reset value 0, cleared on start.
  - For N==0, the checksum byte is still required and must be 8'h00.
- Undefined: no CSUM state and no err_checksum port; the last WRITE goes directly to DONE.

Test Plan:
- Reset: drive reset low mid-DATA after 2 of 4 bytes → all outputs 0 immediately, no wr_en afterwards. Then start and load N=1 bytes 13,00,00,00 → wr_data=32'h0000_0013.
- Basic load, byte_valid held high: N=3, words 32'h00500093, 32'h00A00113, 32'h002081B3 → three wr_en pulses at wr_addr 0x0, 0x4, 0x8. Then done=1, cpu_hold=0, word_count=3.
- Backpressure and gaps: same image with byte_valid low 0–3 random cycles between bytes → identical writes. byte_ready=0 on every WRITE cycle, and no byte is lost or duplicated.
- Boundaries:
  - N=0 → DONE with no wr_en.
  - N=MEM_DEPTH(64) → last wr_addr=0xFC.
  - N=65 → ERROR, err_overflow=1, cpu_hold=1, zero writes.
- start ignored and restart: pulse start during DATA → no effect. After DONE, start with N=1 word 32'hDEADBEEF → done clears on start, wr_addr=0x0, then done=1.
- With LOADER_CHECKSUM_EN: N=1, bytes 01,02,04,08, checksum 0F → done=1. Repeat with checksum 0E → err_checksum=1, cpu_hold=1, done=0.
